cntr_burst_arb: RTL and testbench

// Round-robin arbiter/sequencer sharing one four_bit_sync_cntr_beh instance between two requesters.

---
 rtl/cntr_burst_arb.sv | 107 ++++++++++
 tb/tb_cntr_burst_arb.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cntr_burst_arb.sv
// Round-robin burst sequencer sharing one 4-bit counter between two requesters.
// Owns cnt_en: enables the counter for LEN cycles per grant and tallies carries.
//
//  state | meaning
//  IDLE  | no owner; pick a winner when any req is high
//  RUN   | cnt_en high; remaining counts down, carries accumulate
//  DONE  | one-cycle done pulse to owner; result outputs valid
module cntr_burst_arb #(
    parameter int LEN_W = 8,
    parameter int CAR_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [1:0]       req,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic             abort,
    input  logic [3:0]       count,
    input  logic             carry,
    output logic             cnt_en,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             aborted,
    output logic [CAR_W-1:0] carries,
    output logic [3:0]       start_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic             owner, owner_nxt;
    logic             last_gnt, last_gnt_nxt;
    logic [LEN_W-1:0] remaining, remaining_nxt;
    logic [CAR_W-1:0] carries_nxt;
    logic [3:0]       start_cnt_nxt;
    logic             ab_q, ab_nxt;
    logic             win;
    logic [LEN_W-1:0] win_len;
    logic [1:0]       owner_oh;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last_gnt  <= 1'b1;   // pretend requester 1 went last so requester 0 wins a tie
            remaining <= '0;
            carries   <= '0;
            start_cnt <= '0;
            ab_q      <= 1'b0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            last_gnt  <= last_gnt_nxt;
            remaining <= remaining_nxt;
            carries   <= carries_nxt;
            start_cnt <= start_cnt_nxt;
            ab_q      <= ab_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        last_gnt_nxt  = last_gnt;
        remaining_nxt = remaining;
        carries_nxt   = carries;
        start_cnt_nxt = start_cnt;
        ab_nxt        = ab_q;
        win           = (req == 2'b11) ? ~last_gnt : req[1];
        win_len       = win ? len1 : len0;
        case (state)
            IDLE: begin
                if (|req) begin
                    owner_nxt     = win;
                    remaining_nxt = win_len;
                    start_cnt_nxt = count;
                    carries_nxt   = '0;
                    ab_nxt        = 1'b0;
                    state_nxt     = (win_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                remaining_nxt = remaining - LEN_W'(1);
                if (carry && (carries != {CAR_W{1'b1}}))
                    carries_nxt = carries + CAR_W'(1);
                if (abort) begin
                    ab_nxt    = 1'b1;
                    state_nxt = DONE;
                end else if (remaining == LEN_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                last_gnt_nxt = owner;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign owner_oh = owner ? 2'b10 : 2'b01;
    assign cnt_en   = (state == RUN);
    assign gnt      = (state != IDLE) ? owner_oh : 2'b00;
    assign done     = (state == DONE) ? owner_oh : 2'b00;
    assign aborted  = (state == DONE) && ab_q;

endmodule

// File: tb/tb_cntr_burst_arb.sv
// Self-checking bench for cntr_burst_arb with a behavioural 4-bit counter attached.
// Directed table rows, a mid-burst reset sequence, then randomized bursts against a burst-level model.
module tb_cntr_burst_arb;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] req;
    logic [7:0] len0, len1;
    logic       abort;
    logic [3:0] count;
    logic       carry;
    logic       cnt_en;
    logic [1:0] gnt, done;
    logic       aborted;
    logic [4:0] carries;
    logic [3:0] start_cnt;

    int checks = 0;
    int errors = 0;
    int mcount = 0;   // model counter value
    int mlast  = 1;   // model last-granted requester
    bit from_done = 0;

    always #5 clk = ~clk;

    cntr_burst_arb #(.LEN_W(8), .CAR_W(5)) dut (
        .clk(clk), .rstn(rstn), .req(req), .len0(len0), .len1(len1),
        .abort(abort), .count(count), .carry(carry), .cnt_en(cnt_en),
        .gnt(gnt), .done(done), .aborted(aborted), .carries(carries),
        .start_cnt(start_cnt)
    );

    // behavioural stand-in for four_bit_sync_cntr_beh
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       count <= 4'h0;
        else if (cnt_en) count <= count + 4'h1;
    end
    assign carry = cnt_en && (count == 4'hF);

    typedef struct {
        bit       rst;
        bit [1:0] r;
        int       l0, l1, ab;
        bit [1:0] e_gnt;
        int       e_n, e_car, e_start;
        bit       e_ab;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; req = 2'b00; abort = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        mcount = 0; mlast = 1; from_done = 0;
    endtask

    // Runs one burst starting at a negedge; returns at the negedge where done is seen.
    task automatic burst(input bit [1:0] r, input int l0, input int l1, input int ab,
                         input bit [1:0] e_gnt, input int e_n, input int e_car,
                         input int e_start, input bit e_ab);
        int waited = 0;
        int n = 0;
        int guard = 0;
        req = r; len0 = 8'(l0); len1 = 8'(l1); abort = 1'b0;
        do begin
            @(negedge clk);
            waited++;
        end while (gnt == 2'b00 && waited < 10);
        chk("grant_latency", waited, from_done ? 2 : 1);
        chk("gnt", gnt, e_gnt);
        chk("start_cnt", start_cnt, e_start);
        while (done == 2'b00 && guard < 400) begin
            if (cnt_en) begin
                n++;
                abort = (n == ab);
                len0 = 8'($urandom);  // late len changes must not matter
                len1 = 8'($urandom);
                req  = 2'($urandom);  // req drops during RUN are ignored
            end else begin
                abort = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        abort = 1'b0;
        chk("done_timeout", (guard < 400) ? 1 : 0, 1);
        chk("enable_cycles", n, e_n);
        chk("done", done, e_gnt);
        chk("gnt_at_done", gnt, e_gnt);
        chk("cnt_en_at_done", cnt_en, 0);
        chk("aborted", aborted, e_ab);
        chk("carries", carries, e_car);
        chk("end_count", count, (e_start + e_n) % 16);
        mcount = (e_start + e_n) % 16;
        mlast = e_gnt[1];
        from_done = 1;
    endtask

    initial begin
        rstn = 1'b0; req = 2'b00; len0 = '0; len1 = '0; abort = 1'b0;
        #1;
        chk("rst_cnt_en", cnt_en, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_carries", carries, 0);
        chk("rst_start_cnt", start_cnt, 0);

        //            rst r      l0  l1  ab gnt    n   car start ab
        vecs.push_back('{1, 2'b01,  5,  0, 0, 2'b01,  5, 0,  0, 0});
        vecs.push_back('{1, 2'b01, 20,  0, 0, 2'b01, 20, 1,  0, 0});
        vecs.push_back('{1, 2'b11,  3,  4, 0, 2'b01,  3, 0,  0, 0});
        vecs.push_back('{0, 2'b11,  3,  4, 0, 2'b10,  4, 0,  3, 0});
        vecs.push_back('{0, 2'b11,  3,  4, 0, 2'b01,  3, 0,  7, 0});
        vecs.push_back('{0, 2'b11,  3,  4, 0, 2'b10,  4, 0, 10, 0});
        vecs.push_back('{0, 2'b10,  9,  0, 0, 2'b10,  0, 0, 14, 0});
        vecs.push_back('{0, 2'b01, 50,  7, 3, 2'b01,  3, 1, 14, 1});
        vecs.push_back('{0, 2'b11,  2,  2, 0, 2'b10,  2, 0,  1, 0});
        vecs.push_back('{0, 2'b01,255,  0, 0, 2'b01,255,16,  3, 0});
        vecs.push_back('{0, 2'b01,  4,  0, 4, 2'b01,  4, 0,  2, 1});
        vecs.push_back('{0, 2'b10,  0,  1, 0, 2'b10,  1, 0,  6, 0});
        vecs.push_back('{0, 2'b01,  1,  0, 0, 2'b01,  1, 0,  7, 0});

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            burst(vecs[i].r, vecs[i].l0, vecs[i].l1, vecs[i].ab, vecs[i].e_gnt,
                  vecs[i].e_n, vecs[i].e_car, vecs[i].e_start, vecs[i].e_ab);
        end

        // reset in the 4th RUN cycle of a burst; last-granted was requester 0
        begin
            int n = 0;
            int guard = 0;
            req = 2'b01; len0 = 8'd50;
            @(negedge clk);
            while (n < 4 && guard < 20) begin
                @(negedge clk);
                if (cnt_en) n++;
                guard++;
            end
            chk("mid_rst_reached", n, 4);
            #2 rstn = 1'b0;
            #1;
            chk("mid_rst_cnt_en", cnt_en, 0);
            chk("mid_rst_gnt", gnt, 0);
            chk("mid_rst_done", done, 0);
            req = 2'b00;
            repeat (2) begin
                @(negedge clk);
                chk("mid_rst_no_done", done, 0);
            end
            rstn = 1'b1;
            mcount = 0; mlast = 1; from_done = 0;
            burst(2'b11, 2, 6, 0, 2'b01, 2, 0, 0, 0);
        end

        // randomized bursts against the burst-level model
        for (int k = 0; k < 60; k++) begin
            bit [1:0] r;
            int l0, l1, ab, own, len, n, car;
            r  = 2'($urandom_range(1, 3));
            l0 = $urandom_range(0, 40);
            l1 = $urandom_range(0, 40);
            own = (r == 2'b11) ? (mlast == 0 ? 1 : 0) : (r == 2'b10 ? 1 : 0);
            len = own ? l1 : l0;
            ab  = (len > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, len) : 0;
            n   = (ab > 0) ? ab : len;
            car = 0;
            for (int j = 0; j < n; j++)
                if ((mcount + j) % 16 == 15) car++;
            if (car > 31) car = 31;
            burst(r, l0, l1, ab, own ? 2'b10 : 2'b01, n, car, mcount, ab > 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
